// File: rtl/gpu_def.sv
// Shared definitions for the GPU dispatch slice: FSM encoding,
// load-flag priority and default parameter values.
package gpu_def;

   localparam int CORE_NUM_DEF = 16;
   localparam int BUS_W_DEF    = 16;
   localparam int IMEM_AW_DEF  = 10;
   localparam int IDLE_TMO_DEF = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } disp_state_e;

   // Encoded in priority order: a lower code wins over a higher one.
   typedef enum logic [2:0] {
      FLG_NONE      = 3'd0,
      FLG_CORE_MASK = 3'd1,
      FLG_R0_MASK   = 3'd2,
      FLG_R0_DATA   = 3'd3,
      FLG_INSTR     = 3'd4
   } load_flag_e;

   function automatic load_flag_e decode_flags(
      input logic core_mask_ld,
      input logic r0_mask_ld,
      input logic r0_ld,
      input logic instr_ld
   );
      load_flag_e flag_v;
      if (core_mask_ld) begin
         flag_v = FLG_CORE_MASK;
      end else if (r0_mask_ld) begin
         flag_v = FLG_R0_MASK;
      end else if (r0_ld) begin
         flag_v = FLG_R0_DATA;
      end else if (instr_ld) begin
         flag_v = FLG_INSTR;
      end else begin
         flag_v = FLG_NONE;
      end
      return flag_v;
   endfunction

endpackage

// File: rtl/nth_bit_sel.sv
// Returns a one-hot vector marking the index-th set bit of mask (counted
// from bit 0 upwards); all zeros when mask has no such bit.
module nth_bit_sel #(
   parameter int N  = 16,
   parameter int IW = $clog2(N + 1)
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] index,
   output logic [N-1:0]  onehot
);

   logic [IW-1:0] cnt_s;

   // Running count of set bits below position i selects the matching one.
   always_comb begin
      onehot = '0;
      cnt_s  = '0;
      for (int i = 0; i < N; i++) begin
         onehot[i] = mask[i] & (cnt_s == index);
         cnt_s     = cnt_s + IW'(mask[i]);
      end
   end

endmodule

// File: rtl/dispatch_ctrl.sv
// Task dispatch controller: fans scheduler messages out to per-core R0 and
// instruction buffers, then starts the masked cores when the task closes.
module dispatch_ctrl
   import gpu_def::*;
#(
   parameter int CORE_NUM = CORE_NUM_DEF,
   parameter int BUS_W    = BUS_W_DEF,
   parameter int IMEM_AW  = IMEM_AW_DEF,
   parameter int IDLE_TMO = IDLE_TMO_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BUS_W-1:0]    mess_to_core,
   input  logic                core_mask_loading,
   input  logic                r0_mask_loading,
   input  logic                r0_loading,
   input  logic                instr_loading,
   input  logic [CORE_NUM-1:0] ifetch_ready,
   input  logic [CORE_NUM-1:0] core_done,
   output logic [CORE_NUM-1:0] core_reading,
   output logic [CORE_NUM-1:0] core_ready,
   output logic [CORE_NUM-1:0] core_start,
   output logic [CORE_NUM-1:0] r0_wr_en,
   output logic [CORE_NUM-1:0] ifetch_wr_en,
   output logic [BUS_W-1:0]    wr_data,
   output logic [IMEM_AW-1:0]  ifetch_wr_addr,
   output logic                err_ovf
);

   localparam int IDX_W = $clog2(CORE_NUM + 1);
   localparam int TMO_W = 4;

   disp_state_e         state_r;
   logic [CORE_NUM-1:0] core_mask_r;
   logic [CORE_NUM-1:0] r0_mask_r;
   logic [IDX_W-1:0]    r0_idx_r;
   logic [IMEM_AW-1:0]  addr_r;
   logic [TMO_W-1:0]    tmo_r;
   logic [CORE_NUM-1:0] busy_r;
   logic                err_ovf_r;
   logic [CORE_NUM-1:0] core_start_r;
   logic [CORE_NUM-1:0] r0_wr_en_r;
   logic [CORE_NUM-1:0] ifetch_wr_en_r;
   logic [BUS_W-1:0]    wr_data_r;
   logic [IMEM_AW-1:0]  ifetch_wr_addr_r;

   load_flag_e          flag_s;
   logic [CORE_NUM-1:0] r0_sel_s;

   assign flag_s = decode_flags(core_mask_loading, r0_mask_loading, r0_loading, instr_loading);

   nth_bit_sel #(
      .N  (CORE_NUM),
      .IW (IDX_W)
   ) u_r0_sel (
      .mask   (r0_mask_r),
      .index  (r0_idx_r),
      .onehot (r0_sel_s)
   );

   // Load FSM with registered write strobes, data, address and start pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r          <= ST_IDLE;
         core_mask_r      <= '0;
         r0_mask_r        <= '0;
         r0_idx_r         <= '0;
         addr_r           <= '0;
         tmo_r            <= '0;
         err_ovf_r        <= 1'b0;
         core_start_r     <= '0;
         r0_wr_en_r       <= '0;
         ifetch_wr_en_r   <= '0;
         wr_data_r        <= '0;
         ifetch_wr_addr_r <= '0;
      end else begin
         wr_data_r      <= mess_to_core;
         core_start_r   <= '0;
         r0_wr_en_r     <= '0;
         ifetch_wr_en_r <= '0;
         case (state_r)
            ST_IDLE: begin
               if (flag_s == FLG_CORE_MASK) begin
                  core_mask_r <= mess_to_core[CORE_NUM-1:0];
                  r0_idx_r    <= '0;
                  addr_r      <= '0;
                  tmo_r       <= '0;
                  state_r     <= ST_LOAD;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               case (flag_s)
                  FLG_CORE_MASK: begin
                     // A new mask closes the running task immediately.
                     core_start_r <= core_mask_r;
                     core_mask_r  <= mess_to_core[CORE_NUM-1:0];
                     r0_idx_r     <= '0;
                     addr_r       <= '0;
                     tmo_r        <= '0;
                  end
                  FLG_R0_MASK: begin
                     r0_mask_r <= mess_to_core[CORE_NUM-1:0];
                     r0_idx_r  <= '0;
                     tmo_r     <= '0;
                  end
                  FLG_R0_DATA: begin
                     if (|r0_sel_s) begin
                        r0_wr_en_r <= r0_sel_s;
                        r0_idx_r   <= r0_idx_r + IDX_W'(1);
                     end else begin
                        err_ovf_r  <= 1'b1;
                     end
                     tmo_r <= '0;
                  end
                  FLG_INSTR: begin
                     ifetch_wr_en_r   <= core_mask_r;
                     ifetch_wr_addr_r <= addr_r;
                     addr_r           <= addr_r + IMEM_AW'(1);
                     if (addr_r == {IMEM_AW{1'b1}}) begin
                        err_ovf_r <= 1'b1;
                     end else begin
                        err_ovf_r <= err_ovf_r;
                     end
                     tmo_r <= '0;
                  end
                  default: begin
                     if (tmo_r == TMO_W'(IDLE_TMO - 1)) begin
                        core_start_r <= core_mask_r;
                        tmo_r        <= '0;
                        state_r      <= ST_IDLE;
                     end else begin
                        tmo_r        <= tmo_r + TMO_W'(1);
                     end
                  end
               endcase
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Busy tracking: a start pulse outweighs a same-cycle done on one core.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= '0;
      end else begin
         busy_r <= (busy_r & ~core_done) | core_start_r;
      end
   end

   assign core_ready     = ~busy_r;
   assign core_reading   = (state_r == ST_LOAD) ? (ifetch_ready | ~core_mask_r)
                                                : {CORE_NUM{1'b1}};
   assign core_start     = core_start_r;
   assign r0_wr_en       = r0_wr_en_r;
   assign ifetch_wr_en   = ifetch_wr_en_r;
   assign wr_data        = wr_data_r;
   assign ifetch_wr_addr = ifetch_wr_addr_r;
   assign err_ovf        = err_ovf_r;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl.
module tb_dispatch_ctrl;

   localparam logic [3:0] F_CM = 4'b1000;
   localparam logic [3:0] F_RM = 4'b0100;
   localparam logic [3:0] F_R0 = 4'b0010;
   localparam logic [3:0] F_IN = 4'b0001;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mess_to_core;
   logic        core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
   logic [15:0] ifetch_ready, core_done;
   logic [15:0] core_reading, core_ready, core_start, r0_wr_en, ifetch_wr_en, wr_data;
   logic [9:0]  ifetch_wr_addr;
   logic        err_ovf;

   int n_vec = 0;
   int n_err = 0;

   dispatch_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .mess_to_core      (mess_to_core),
      .core_mask_loading (core_mask_loading),
      .r0_mask_loading   (r0_mask_loading),
      .r0_loading        (r0_loading),
      .instr_loading     (instr_loading),
      .ifetch_ready      (ifetch_ready),
      .core_done         (core_done),
      .core_reading      (core_reading),
      .core_ready        (core_ready),
      .core_start        (core_start),
      .r0_wr_en          (r0_wr_en),
      .ifetch_wr_en      (ifetch_wr_en),
      .wr_data           (wr_data),
      .ifetch_wr_addr    (ifetch_wr_addr),
      .err_ovf           (err_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] f, input logic [15:0] d);
      {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = f;
      mess_to_core = d;
      tick();
      {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0000;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      core_done = 16'h0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (core_ready !== 16'hFFFF) begin n_err++; $display("FAIL rst_ready: got %h exp FFFF", core_ready); end
      n_vec++; if (core_reading !== 16'hFFFF) begin n_err++; $display("FAIL rst_reading: got %h exp FFFF", core_reading); end
      n_vec++; if (core_start !== 16'h0000) begin n_err++; $display("FAIL rst_start: got %h exp 0000", core_start); end
      n_vec++; if ({r0_wr_en, ifetch_wr_en} !== 32'h0) begin n_err++; $display("FAIL rst_strobes: got %h exp 0", {r0_wr_en, ifetch_wr_en}); end
      n_vec++; if ({wr_data, ifetch_wr_addr, err_ovf} !== 27'h0) begin n_err++; $display("FAIL rst_data: got %h exp 0", {wr_data, ifetch_wr_addr, err_ovf}); end
   endtask

   task automatic test_instr();
      logic [15:0] exp_d;
      send(F_CM, 16'h00F0);
      n_vec++; if (core_start !== 16'h0000) begin n_err++; $display("FAIL instr_nostart: got %h exp 0000", core_start); end
      ifetch_ready = 16'hFF0F;
      #1;
      n_vec++; if (core_reading !== 16'hFF0F) begin n_err++; $display("FAIL instr_reading: got %h exp FF0F", core_reading); end
      ifetch_ready = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         exp_d = 16'hA001 + 16'(k);
         send(F_IN, exp_d);
         n_vec++; if (ifetch_wr_en !== 16'h00F0) begin n_err++; $display("FAIL instr_en[%0d]: got %h exp 00F0", k, ifetch_wr_en); end
         n_vec++; if (ifetch_wr_addr !== 10'(k)) begin n_err++; $display("FAIL instr_addr[%0d]: got %0d exp %0d", k, ifetch_wr_addr, k); end
         n_vec++; if (wr_data !== exp_d) begin n_err++; $display("FAIL instr_data[%0d]: got %h exp %h", k, wr_data, exp_d); end
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_d = (i == 4) ? 16'h00F0 : 16'h0000;
         n_vec++; if (core_start !== exp_d) begin n_err++; $display("FAIL instr_tmo[%0d]: got %h exp %h", i, core_start, exp_d); end
      end
      tick();
      n_vec++; if (core_start !== 16'h0000) begin n_err++; $display("FAIL instr_pulse: got %h exp 0000", core_start); end
      n_vec++; if (core_ready !== 16'hFF0F) begin n_err++; $display("FAIL instr_busy: got %h exp FF0F", core_ready); end
      ifetch_ready = 16'h0000;
      #1;
      n_vec++; if (core_reading !== 16'hFFFF) begin n_err++; $display("FAIL idle_reading: got %h exp FFFF", core_reading); end
      ifetch_ready = 16'hFFFF;
      core_done = 16'h00F0;
      tick();
      core_done = 16'h0000;
      n_vec++; if (core_ready !== 16'hFFFF) begin n_err++; $display("FAIL instr_done: got %h exp FFFF", core_ready); end
      n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL instr_err: got %b exp 0", err_ovf); end
   endtask

   task automatic test_r0();
      logic [15:0] exp_en [4];
      logic [15:0] exp_d;
      exp_en = '{16'h0002, 16'h0004, 16'h0100, 16'h0000};
      send(F_CM, 16'h0001);
      send(F_RM | F_R0, 16'h0106);
      n_vec++; if (r0_wr_en !== 16'h0000) begin n_err++; $display("FAIL r0_prio: got %h exp 0000", r0_wr_en); end
      for (int k = 0; k < 4; k++) begin
         exp_d = 16'hB000 + 16'(k);
         send(F_R0, exp_d);
         n_vec++; if (r0_wr_en !== exp_en[k]) begin n_err++; $display("FAIL r0_en[%0d]: got %h exp %h", k, r0_wr_en, exp_en[k]); end
         n_vec++; if (wr_data !== exp_d) begin n_err++; $display("FAIL r0_data[%0d]: got %h exp %h", k, wr_data, exp_d); end
         n_vec++; if (err_ovf !== (k == 3)) begin n_err++; $display("FAIL r0_err[%0d]: got %b exp %b", k, err_ovf, (k == 3)); end
      end
      send(F_CM, 16'h0000);
      n_vec++; if (core_start !== 16'h0001) begin n_err++; $display("FAIL r0_close: got %h exp 0001", core_start); end
      send(F_IN, 16'h1234);
      n_vec++; if (ifetch_wr_en !== 16'h0000) begin n_err++; $display("FAIL zero_mask_en: got %h exp 0000", ifetch_wr_en); end
      core_done = 16'h0001;
      tick();
      core_done = 16'h0000;
      tick();
      tick();
      tick();
      n_vec++; if (core_start !== 16'h0000) begin n_err++; $display("FAIL zero_mask_start: got %h exp 0000", core_start); end
      n_vec++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b exp 1", err_ovf); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send(F_CM, 16'h0003);
      send(F_CM | F_IN, 16'h000C);
      n_vec++; if (core_start !== 16'h0003) begin n_err++; $display("FAIL b2b_start: got %h exp 0003", core_start); end
      n_vec++; if (ifetch_wr_en !== 16'h0000) begin n_err++; $display("FAIL b2b_prio: got %h exp 0000", ifetch_wr_en); end
      tick();
      n_vec++; if (core_ready !== 16'hFFFC) begin n_err++; $display("FAIL b2b_ready: got %h exp FFFC", core_ready); end
      tick();
      tick();
      tick();
      n_vec++; if (core_start !== 16'h000C) begin n_err++; $display("FAIL b2b_tmo: got %h exp 000C", core_start); end
      tick();
      n_vec++; if (core_ready !== 16'hFFF0) begin n_err++; $display("FAIL b2b_busy: got %h exp FFF0", core_ready); end
      core_done = 16'h000F;
      tick();
      core_done = 16'h0000;
      n_vec++; if (core_ready !== 16'hFFFF) begin n_err++; $display("FAIL b2b_done: got %h exp FFFF", core_ready); end
   endtask

   task automatic test_collision();
      do_reset();
      send(F_CM, 16'h0001);
      send(F_CM, 16'h0000);
      n_vec++; if (core_start !== 16'h0001) begin n_err++; $display("FAIL col_start: got %h exp 0001", core_start); end
      core_done = 16'h0001;
      tick();
      core_done = 16'h0000;
      n_vec++; if (core_ready !== 16'hFFFE) begin n_err++; $display("FAIL col_same: got %h exp FFFE", core_ready); end
      tick();
      n_vec++; if (core_ready !== 16'hFFFE) begin n_err++; $display("FAIL col_hold: got %h exp FFFE", core_ready); end
      core_done = 16'h0001;
      tick();
      core_done = 16'h0000;
      n_vec++; if (core_ready !== 16'hFFFF) begin n_err++; $display("FAIL col_done: got %h exp FFFF", core_ready); end
   endtask

   task automatic test_wrap();
      do_reset();
      send(F_CM, 16'h8000);
      for (int i = 0; i <= 1024; i++) begin
         send(F_IN, 16'(i));
         if (i == 1022) begin
            n_vec++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL wrap_early: got %b exp 0", err_ovf); end
         end
         if (i == 1023) begin
            n_vec++; if (ifetch_wr_addr !== 10'h3FF) begin n_err++; $display("FAIL wrap_top: got %h exp 3FF", ifetch_wr_addr); end
            n_vec++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL wrap_err: got %b exp 1", err_ovf); end
         end
         if (i == 1024) begin
            n_vec++; if (ifetch_wr_addr !== 10'h000) begin n_err++; $display("FAIL wrap_zero: got %h exp 000", ifetch_wr_addr); end
            n_vec++; if (ifetch_wr_en !== 16'h8000) begin n_err++; $display("FAIL wrap_en: got %h exp 8000", ifetch_wr_en); end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [15:0] seen;
      do_reset();
      send(F_CM, 16'h00FF);
      send(F_IN, 16'h5555);
      n_vec++; if (ifetch_wr_en !== 16'h00FF) begin n_err++; $display("FAIL mid_en: got %h exp 00FF", ifetch_wr_en); end
      reset = 1'b1;
      mess_to_core = 16'h0000;
      tick();
      n_vec++; if ({core_start, r0_wr_en, ifetch_wr_en} !== 48'h0) begin n_err++; $display("FAIL mid_strobes: got %h exp 0", {core_start, r0_wr_en, ifetch_wr_en}); end
      n_vec++; if ({wr_data, ifetch_wr_addr, err_ovf} !== 27'h0) begin n_err++; $display("FAIL mid_data: got %h exp 0", {wr_data, ifetch_wr_addr, err_ovf}); end
      n_vec++; if (core_ready !== 16'hFFFF) begin n_err++; $display("FAIL mid_ready: got %h exp FFFF", core_ready); end
      n_vec++; if (core_reading !== 16'hFFFF) begin n_err++; $display("FAIL mid_reading: got %h exp FFFF", core_reading); end
      reset = 1'b0;
      seen = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | core_start;
      end
      n_vec++; if (seen !== 16'h0000) begin n_err++; $display("FAIL mid_nostart: got %h exp 0000", seen); end
   endtask

   initial begin
      reset = 1'b1;
      mess_to_core = 16'h0000;
      {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = 4'b0000;
      ifetch_ready = 16'hFFFF;
      core_done = 16'h0000;
      test_reset();
      test_instr();
      test_r0();
      test_back_to_back();
      test_collision();
      test_wrap();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
